// File: rtl/perm_engine_if.sv
// ---------------------------------------------------------------------------
// perm_engine_if
// Bundles the data handshake and configuration signals of perm_engine.
//
// Handshake semantics (both channels): a word transfers on a rising clock
// edge where valid && ready are both high. The sender keeps valid and its
// payload stable until the transfer happens. The receiver may change ready
// at any time.
//
// Signals:
//   in_valid/in_ready/in_data/inv  : input word channel (inv sampled with it)
//   out_valid/out_ready/out_data   : permuted output word channel
//   cfg_we/cfg_addr/cfg_data       : table write port (T[cfg_addr] = cfg_data)
//   cfg_err                        : one-cycle pulse after a rejected write
//   perm_ok                        : table is currently a bijection
//
// Modports: master = traffic source / sink (testbench or host),
//           slave  = the permutation engine.
// ---------------------------------------------------------------------------
interface perm_engine_if #(
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             inv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [AW-1:0]    cfg_data;
    logic             cfg_err;
    logic             perm_ok;

    modport master (
        output in_valid, in_data, inv, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_data, cfg_err, perm_ok
    );

    modport slave (
        input  in_valid, in_data, inv, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_data, cfg_err, perm_ok
    );
endinterface

// File: rtl/perm_engine.sv
// ---------------------------------------------------------------------------
// perm_engine
// Programmable bit permutation with one output register stage.
// Bit numbering is 1..WIDTH with bit 1 the LSB; the table T[1..WIDTH] holds
// source-bit indices.
//   forward : out[i]    = in[T[i]]
//   inverse : out[T[i]] = in[i]   (untargeted positions read 0,
//                                  highest i wins on duplicate targets)
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (restores the default table)
//   bus  : perm_engine_if.slave, carries the data handshake and cfg port.
//          The interface WIDTH must match this module's WIDTH.
// ---------------------------------------------------------------------------
module perm_engine #(
    parameter int WIDTH       = 32,
    parameter int DES_DEFAULT = 1
) (
    input  logic         clk,
    input  logic         rst,
    perm_engine_if.slave bus
);
    localparam int AW = $clog2(WIDTH + 1);
    localparam bit USE_DES = (DES_DEFAULT == 1) && (WIDTH == 32);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam int DES_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // table_q[k] holds T[k+1]
    logic [AW-1:0]    table_q [WIDTH];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             cfg_err_q, cfg_err_d;
    logic             perm_ok_q, perm_ok_d;
    logic             accept;
    logic             cfg_ok;
    logic [WIDTH-1:0] fwd_word;
    logic [WIDTH-1:0] inv_word;
    logic [WIDTH-1:0] fwd_shift;
    logic [WIDTH-1:0] inv_mask;
    logic [WIDTH-1:0] seen;

    function automatic logic [AW-1:0] reset_entry(input int idx);
        logic [4:0] k;
        k = 5'(idx);
        if (USE_DES) begin
            return AW'(DES_TAB[k]);
        end
        return AW'(idx + 1);
    endfunction

    // A write lands only when both the address and the value are in 1..WIDTH,
    // so the table never holds an out-of-range index.
    assign cfg_ok = (bus.cfg_addr != '0) && (int'(bus.cfg_addr) <= WIDTH) &&
                    (bus.cfg_data != '0) && (int'(bus.cfg_data) <= WIDTH);
    assign cfg_err_d = bus.cfg_we && !cfg_ok;

    // The output register frees up either when empty or when being drained.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Forward gather: each output bit picks its source bit via a shift.
    always_comb begin
        fwd_word  = '0;
        fwd_shift = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fwd_shift   = bus.in_data >> (table_q[i] - AW'(1));
            fwd_word[i] = fwd_shift[0];
        end
    end

    // Inverse scatter: entries processed in increasing i so a later entry
    // overwrites an earlier one that targets the same position.
    always_comb begin
        inv_word = '0;
        inv_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            inv_mask = ONE << (table_q[i] - AW'(1));
            inv_word = bus.in_data[i] ? (inv_word | inv_mask)
                                      : (inv_word & ~inv_mask);
        end
    end

    // WIDTH in-range entries cover every value exactly once iff every value
    // is covered at least once.
    always_comb begin
        seen = '0;
        for (int i = 0; i < WIDTH; i++) begin
            seen = seen | (ONE << (table_q[i] - AW'(1)));
        end
        perm_ok_d = &seen;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.inv ? inv_word : fwd_word;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            perm_ok_q   <= 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                table_q[i] <= reset_entry(i);
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_err_q   <= cfg_err_d;
            // Sees the table before this edge, so it trails a write by a cycle.
            perm_ok_q   <= perm_ok_d;
            for (int i = 0; i < WIDTH; i++) begin
                if (bus.cfg_we && cfg_ok && (bus.cfg_addr == AW'(i + 1))) begin
                    table_q[i] <= bus.cfg_data;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.perm_ok   = perm_ok_q;

endmodule

// File: doc/perm_engine.md
PERM_ENGINE -- requirements
Module: perm_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width in bits; legal range 2..64.
REQ-002 SHALL have parameter DES_DEFAULT, default 1, meaning the reset table is the DES P-box when 1 and WIDTH==32, and identity otherwise.
REQ-003 SHALL use AW = clog2(WIDTH+1) for address and table-entry widths.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, input word present.
REQ-007 SHALL have port in_ready, output, 1, input word accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data, input, WIDTH, input word; bit numbering 1..WIDTH, bit 1 = LSB.
REQ-009 SHALL have port inv, input, 1, sampled with the input word; 0 = forward, 1 = inverse.
REQ-010 SHALL have port out_valid, output, 1, output word present.
REQ-011 SHALL have port out_ready, input, 1, output word consumed when out_valid && out_ready.
REQ-012 SHALL have port out_data, output, WIDTH, permuted word.
REQ-013 SHALL have port cfg_we, input, 1, table write strobe.
REQ-014 SHALL have port cfg_addr, input, AW, output-bit index i to write (1..WIDTH).
REQ-015 SHALL have port cfg_data, input, AW, source-bit index T[i] (1..WIDTH).
REQ-016 SHALL have port cfg_err, output, 1, one-cycle pulse on a rejected write.
REQ-017 SHALL have port perm_ok, output, 1, registered flag: table is a bijection.

Function
REQ-018 Forward: out_data[i] SHALL equal in_data[T[i]] for every i in 1..WIDTH.
REQ-019 Inverse: out_data[T[i]] SHALL equal in_data[i]; positions no entry targets SHALL read 0; on duplicate targets the highest i SHALL win.
REQ-020 Latency SHALL be exactly 1 cycle from acceptance to out_valid, with one output register stage.
REQ-021 in_ready SHALL equal !out_valid || out_ready, giving full throughput of 1 word/cycle under no backpressure.
REQ-022 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-023 out_valid SHALL clear after a consume with no new acceptance in the same cycle.
REQ-024 A cfg write SHALL be rejected, with cfg_err pulsing the next cycle and the table unchanged, when cfg_addr is 0 or >WIDTH, or cfg_data is 0 or >WIDTH.
REQ-025 An accepted cfg write SHALL update T[cfg_addr] at the clock edge.
REQ-026 An input word accepted in the same cycle as a cfg write SHALL use the old table; the next accepted word SHALL use the new table.
REQ-027 Data SHALL NOT stall for cfg writes.
REQ-028 perm_ok SHALL be recomputed from the table and registered one cycle after any table change: 1 iff every value 1..WIDTH appears exactly once.
REQ-029 Inverse-mode transfers SHALL be accepted even when perm_ok=0, following the REQ-019 rules.

Reset
REQ-030 On rst: out_valid=0, out_data=0, and cfg_err=0 SHALL hold immediately.
REQ-031 On rst: the table SHALL be restored per DES_DEFAULT and perm_ok=1.
REQ-032 On rst: an in-flight output word SHALL be discarded.
REQ-033 DES table T[1..32] SHALL be 16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25.
REQ-034 Identity table SHALL be T[i]=i.

Verification
REQ-035 Reset (WIDTH=32, DES) then in_data=0x00000001, inv=0 -> one cycle later out_valid=1, out_data=0x00000100.
REQ-036 in_data=0x00008000, inv=0 -> 0x00000001. Then 0x00000100, inv=1 -> 0x00000001.
REQ-037 Stream of 4 words with out_ready=0 from cycle 2 -> in_ready=0, out_data holds word 1. On out_ready=1, words 2..4 emerge on consecutive cycles in order.
REQ-038 cfg_addr=0 or cfg_data=33 -> cfg_err pulses 1 cycle, table and perm_ok unchanged. cfg_addr=1, cfg_data=7 -> perm_ok=0. Then forward in_data=0x00000040 -> out bits 1 and 2 set (0x00000003).
REQ-039 cfg write and input acceptance in the same cycle -> that word uses the old mapping and the next word uses the new one. Assert rst while out_valid=1 -> out_valid=0 asynchronously, DES table restored.
